// File: rtl/lpc_rx.sv
// lpc_rx: serial byte receiver that writes fixed-size packets into the sound buffer RAM
module lpc_rx #(
  parameter int BIT_PERIOD = 51,
  parameter int PACKET_BYTES = 2048,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [14:0] wraddress,
  output logic [7:0]  wdata,
  output logic        wren,
  output logic        packet_RCVD,
  output logic        pkt_abort,
  output logic        frame_err,
  output logic        rx_bsy,
  output logic [11:0] real_pack
);
  localparam int HALF = BIT_PERIOD / 2;
  localparam int TO = TIMEOUT_BITS * BIT_PERIOD;
  localparam int CW = $clog2(BIT_PERIOD);
  localparam int IW = $clog2(TO + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic s1_q, rs_q, rs_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, wdata_q, wdata_d;
  logic [14:0] wraddress_q, wraddress_d, pkt_base_q, pkt_base_d;
  logic [11:0] real_pack_q, real_pack_d;
  logic [IW-1:0] idle_q, idle_d;
  logic wren_q, wren_d, packet_rcvd_q, packet_rcvd_d, pkt_abort_q, pkt_abort_d;
  logic frame_err_q, frame_err_d, rx_bsy_q, rx_bsy_d;
  logic fall;
  assign fall = rs_prev_q & ~rs_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    sh_d = sh_q;
    wdata_d = wdata_q;
    wren_d = 1'b0;
    packet_rcvd_d = 1'b0;
    pkt_abort_d = 1'b0;
    frame_err_d = 1'b0;
    wraddress_d = wraddress_q;
    real_pack_d = real_pack_q;
    rx_bsy_d = rx_bsy_q;
    pkt_base_d = pkt_base_q;
    idle_d = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rs_q ? IDLE : DATA;
        if (!rs_q && real_pack_q == '0) rx_bsy_d = 1'b1;
      end
      DATA: if (cnt_q == CW'(BIT_PERIOD - 1)) begin
        cnt_d = '0;
        sh_d = {rs_q, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == CW'(BIT_PERIOD - 1)) begin
        cnt_d = '0;
        state_d = rs_q ? IDLE : BREAK;
        wdata_d = rs_q ? sh_q : wdata_q;
        wren_d = rs_q;
        frame_err_d = ~rs_q;
      end
      BREAK: begin
        cnt_d = '0;
        if (rs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wren_q) begin
      wraddress_d = wraddress_q + 15'd1;
      if (real_pack_q == 12'(PACKET_BYTES - 1)) begin
        packet_rcvd_d = 1'b1;
        real_pack_d = '0;
        rx_bsy_d = 1'b0;
        pkt_base_d = wraddress_q + 15'd1;
      end else begin
        real_pack_d = real_pack_q + 12'd1;
      end
    end
    if (state_q == IDLE && real_pack_q != '0 && !fall) begin
      if (idle_q == IW'(TO - 1)) begin
        pkt_abort_d = 1'b1;
        wraddress_d = pkt_base_q;
        real_pack_d = '0;
        rx_bsy_d = 1'b0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s1_q <= 1'b1;
      rs_q <= 1'b1;
      rs_prev_q <= 1'b1;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      wdata_q <= '0;
      wren_q <= 1'b0;
      packet_rcvd_q <= 1'b0;
      pkt_abort_q <= 1'b0;
      frame_err_q <= 1'b0;
      wraddress_q <= '0;
      real_pack_q <= '0;
      rx_bsy_q <= 1'b0;
      pkt_base_q <= '0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q <= rx;
      rs_q <= s1_q;
      rs_prev_q <= rs_q;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      wdata_q <= wdata_d;
      wren_q <= wren_d;
      packet_rcvd_q <= packet_rcvd_d;
      pkt_abort_q <= pkt_abort_d;
      frame_err_q <= frame_err_d;
      wraddress_q <= wraddress_d;
      real_pack_q <= real_pack_d;
      rx_bsy_q <= rx_bsy_d;
      pkt_base_q <= pkt_base_d;
      idle_q <= idle_d;
    end
  end
  assign wraddress = wraddress_q;
  assign wdata = wdata_q;
  assign wren = wren_q;
  assign packet_RCVD = packet_rcvd_q;
  assign pkt_abort = pkt_abort_q;
  assign frame_err = frame_err_q;
  assign rx_bsy = rx_bsy_q;
  assign real_pack = real_pack_q;
endmodule
